// File: rtl/axis_tx_retry_pkg.sv
// Shared types and constants for the half-duplex TX retry controller.
package axis_tx_retry_pkg;

    typedef enum logic [1:0] {
        ST_SEND    = 2'd0,
        ST_JAM     = 2'd1,
        ST_BACKOFF = 2'd2,
        ST_DRAIN   = 2'd3
    } tx_state_e;

    localparam int unsigned DEF_JAM_LEN     = 4;
    localparam int unsigned DEF_SLOT_CYCLES = 64;

    // x^16 + x^14 + x^13 + x^11 + 1, shifting towards the MSB
    localparam int unsigned LFSR_WIDTH = 16;
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;
    localparam logic [15:0] LFSR_SEED  = 16'hACE1;

    function automatic int unsigned clamp_exp(input int unsigned attempts,
                                              input int unsigned limit);
        return (attempts < limit) ? attempts : limit;
    endfunction

endpackage

// File: rtl/axis_tx_retry_lfsr.sv
// Fibonacci LFSR with configurable width, taps and seed; steps every cycle.
module axis_tx_retry_lfsr
    import axis_tx_retry_pkg::*;
#(
    parameter int unsigned           WIDTH = LFSR_WIDTH,
    parameter logic [WIDTH-1:0]      TAPS  = WIDTH'(LFSR_TAPS),
    parameter logic [WIDTH-1:0]      SEED  = WIDTH'(LFSR_SEED)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    output logic [WIDTH-1:0] o_value
);

    logic [WIDTH-1:0] r_value;
    logic             w_fb;

    assign w_fb    = ^(r_value & TAPS);
    assign o_value = r_value;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_value <= SEED;
        end else begin
            r_value <= {r_value[WIDTH-2:0], w_fb};
        end
    end

endmodule

// File: rtl/axis_tx_retry.sv
// Half-duplex MAC TX controller: forwards frames, jams on collision, backs off and
// requests replay from the upstream replay buffer, or drops and drains the frame.
module axis_tx_retry
    import axis_tx_retry_pkg::*;
#(
    parameter int unsigned            DATA_WIDTH    = 9,
    parameter int unsigned            JAM_LEN       = DEF_JAM_LEN,
    parameter logic [DATA_WIDTH-1:0]  JAM_DATA      = DATA_WIDTH'('h55),
    parameter int unsigned            SLOT_CYCLES   = DEF_SLOT_CYCLES,
    parameter int unsigned            MAX_ATTEMPTS  = 16,
    parameter int unsigned            BACKOFF_LIMIT = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_data,
    input  logic                  s_axis_valid,
    output logic                  s_axis_ready,
    input  logic                  s_axis_last,
    input  logic                  replayable,
    output logic                  replay,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] m_axis_data,
    output logic                  m_axis_valid,
    input  logic                  m_axis_ready,
    output logic                  m_axis_last,
    output logic                  m_axis_err,
    input  logic                  col,
    output logic                  tx_ok,
    output logic                  late_col,
    output logic                  excessive
);

    localparam int unsigned ATT_W = $clog2(MAX_ATTEMPTS + 1);
    localparam int unsigned JAM_W = $clog2(JAM_LEN + 1);
    localparam int unsigned CYC_W = $clog2(SLOT_CYCLES);

    localparam logic [ATT_W-1:0] ATT_MAX  = ATT_W'(MAX_ATTEMPTS);
    localparam logic [JAM_W-1:0] JAM_LAST = JAM_W'(JAM_LEN - 1);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(SLOT_CYCLES - 1);

    tx_state_e                r_state, w_next;
    logic [ATT_W-1:0]         r_attempts, w_attempts_inc;
    logic                     r_retry, r_late, r_last_seen;
    logic [JAM_W-1:0]         r_jam_cnt;
    logic [BACKOFF_LIMIT-1:0] r_slot;
    logic [CYC_W-1:0]         r_cyc;
    logic                     r_done, r_tx_ok, r_late_col, r_excessive;
    logic [LFSR_WIDTH-1:0]    w_lfsr, w_mask, w_slot_draw;
    logic [31:0]              w_k;
    logic                     w_send_last, w_jam_end, w_bo_end;

    axis_tx_retry_lfsr #(
        .WIDTH (LFSR_WIDTH),
        .TAPS  (LFSR_TAPS),
        .SEED  (LFSR_SEED)
    ) u_lfsr (
        .i_clk   (clk),
        .i_rst   (rst),
        .o_value (w_lfsr)
    );

    assign w_attempts_inc = r_attempts + ATT_W'(1);
    assign w_k            = clamp_exp(32'(r_attempts), BACKOFF_LIMIT);
    assign w_mask         = LFSR_WIDTH'((32'd1 << w_k) - 32'd1);
    assign w_slot_draw    = w_lfsr & w_mask;
    assign w_send_last    = s_axis_valid && m_axis_ready && s_axis_last;
    assign w_jam_end      = m_axis_ready && (r_jam_cnt == JAM_LAST);
    // Final backoff cycle: nothing to wait for, or last cycle of the last slot
    assign w_bo_end       = (r_slot == '0) ||
                            ((r_slot == BACKOFF_LIMIT'(1)) && (r_cyc == '0));

    always_comb begin
        w_next       = r_state;
        s_axis_ready = 1'b0;
        m_axis_valid = 1'b0;
        m_axis_data  = '0;
        m_axis_last  = 1'b0;
        m_axis_err   = 1'b0;
        replay       = 1'b0;
        unique case (r_state)
            ST_SEND: begin
                s_axis_ready = m_axis_ready;
                m_axis_valid = s_axis_valid;
                m_axis_data  = s_axis_data;
                m_axis_last  = s_axis_last;
                if (col) w_next = ST_JAM;
            end
            ST_JAM: begin
                m_axis_valid = 1'b1;
                m_axis_data  = JAM_DATA;
                m_axis_err   = 1'b1;
                m_axis_last  = (r_jam_cnt == JAM_LAST);
                if (w_jam_end) begin
                    w_next = r_retry ? ST_BACKOFF : (r_last_seen ? ST_SEND : ST_DRAIN);
                end
            end
            ST_BACKOFF: begin
                if (w_bo_end) begin
                    replay = replayable;
                    w_next = ST_SEND;
                end
            end
            ST_DRAIN: begin
                s_axis_ready = 1'b1;
                if (s_axis_valid && s_axis_last) w_next = ST_SEND;
            end
            default: w_next = ST_SEND;
        endcase
        if (rst) begin
            s_axis_ready = 1'b0;
            m_axis_valid = 1'b0;
            m_axis_data  = '0;
            m_axis_last  = 1'b0;
            m_axis_err   = 1'b0;
            replay       = 1'b0;
        end
    end

    assign done      = r_done      && !rst;
    assign tx_ok     = r_tx_ok     && !rst;
    assign late_col  = r_late_col  && !rst;
    assign excessive = r_excessive && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_SEND;
            r_attempts  <= '0;
            r_retry     <= 1'b0;
            r_late      <= 1'b0;
            r_last_seen <= 1'b0;
            r_jam_cnt   <= '0;
            r_slot      <= '0;
            r_cyc       <= '0;
            r_done      <= 1'b0;
            r_tx_ok     <= 1'b0;
            r_late_col  <= 1'b0;
            r_excessive <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_done      <= 1'b0;
            r_tx_ok     <= 1'b0;
            r_late_col  <= 1'b0;
            r_excessive <= 1'b0;
            unique case (r_state)
                ST_SEND: begin
                    if (col) begin
                        r_retry     <= replayable && (w_attempts_inc < ATT_MAX);
                        r_late      <= !replayable;
                        r_last_seen <= w_send_last;
                        r_attempts  <= w_attempts_inc;
                        r_jam_cnt   <= '0;
                    end else if (w_send_last) begin
                        r_done     <= 1'b1;
                        r_tx_ok    <= 1'b1;
                        r_attempts <= '0;
                    end
                end
                ST_JAM: begin
                    if (w_jam_end) begin
                        if (r_retry) begin
                            r_slot <= BACKOFF_LIMIT'(w_slot_draw);
                            r_cyc  <= CYC_LAST;
                        end else begin
                            r_done      <= 1'b1;
                            r_late_col  <= r_late;
                            r_excessive <= !r_late;
                            r_attempts  <= '0;
                        end
                    end else if (m_axis_ready) begin
                        r_jam_cnt <= r_jam_cnt + JAM_W'(1);
                    end
                end
                ST_BACKOFF: begin
                    if (!w_bo_end) begin
                        if (r_cyc == '0) begin
                            r_slot <= r_slot - BACKOFF_LIMIT'(1);
                            r_cyc  <= CYC_LAST;
                        end else begin
                            r_cyc <= r_cyc - CYC_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (s_axis_valid && s_axis_last) r_attempts <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_tx_retry.sv
// Bench for axis_tx_retry: a replay-buffer source model drives frames with planned
// collisions; the observed output stream and status pulses are compared per frame.
module tb_axis_tx_retry;

    localparam int DW   = 9;
    localparam int BUF  = 54;
    localparam int SLOT = 64;
    localparam int BLIM = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_axis_data;
    logic          s_axis_valid, s_axis_ready, s_axis_last, replayable;
    logic          replay, done, tx_ok, late_col, excessive, col;
    logic [DW-1:0] m_axis_data;
    logic          m_axis_valid, m_axis_ready, m_axis_last, m_axis_err;
    logic [17:0]   outs;

    always #5 clk = ~clk;

    axis_tx_retry #(
        .DATA_WIDTH    (DW),
        .JAM_LEN       (4),
        .JAM_DATA      (9'h055),
        .SLOT_CYCLES   (SLOT),
        .MAX_ATTEMPTS  (16),
        .BACKOFF_LIMIT (BLIM)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis_data  (s_axis_data),
        .s_axis_valid (s_axis_valid),
        .s_axis_ready (s_axis_ready),
        .s_axis_last  (s_axis_last),
        .replayable   (replayable),
        .replay       (replay),
        .done         (done),
        .m_axis_data  (m_axis_data),
        .m_axis_valid (m_axis_valid),
        .m_axis_ready (m_axis_ready),
        .m_axis_last  (m_axis_last),
        .m_axis_err   (m_axis_err),
        .col          (col),
        .tx_ok        (tx_ok),
        .late_col     (late_col),
        .excessive    (excessive)
    );

    assign outs = {s_axis_ready, replay, done, m_axis_valid, m_axis_last, m_axis_err,
                   tx_ok, late_col, excessive, m_axis_data};

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [8:0]  fdata[0:127];
    int          plan[0:15];
    logic [10:0] exp_q[$];
    logic [10:0] got_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst = 1'b0; s_axis_valid = 1'b0; s_axis_last = 1'b0; col = 1'b0; m_axis_ready = 1'b1;
            #1;
            check_eq("idle_quiet", {29'd0, m_axis_valid, done, replay}, 32'd0);
        end
    endtask

    // Expected behaviour per attempt: beats 0..c, then 4 jam beats; then replay,
    // or drop (late_col if beat c was not replayable, excessive on the 16th collision).
    task automatic run_frame(input string name, input int L, input int bufsz, input int ncol,
                             input bit full_ready, input bit rst_test);
        int idx, att, jam, t_j, cyc, d, k, rst_left;
        int e_rep, e_ok, e_late, e_exc;
        int n_rep, n_ok, n_late, n_exc, n_done;
        bit armed, active, finished, colnow, gap_ok;
        logic [10:0] g;

        for (int i = 0; i < L; i++) fdata[i] = 9'($urandom);
        exp_q.delete(); got_q.delete();
        e_rep = 0; e_ok = 0; e_late = 0; e_exc = 0;
        if (rst_test) begin
            for (int i = 0; i <= plan[0]; i++) exp_q.push_back({1'b0, 1'(i == L-1), fdata[i]});
            for (int j = 0; j < 4; j++) exp_q.push_back({1'b1, 1'(j == 3), 9'h055});
        end else begin
            for (int a = 1; a <= 16; a++) begin
                if (a > ncol) begin
                    for (int i = 0; i < L; i++) exp_q.push_back({1'b0, 1'(i == L-1), fdata[i]});
                    e_ok = 1;
                    break;
                end
                for (int i = 0; i <= plan[a-1]; i++) exp_q.push_back({1'b0, 1'(i == L-1), fdata[i]});
                for (int j = 0; j < 4; j++) exp_q.push_back({1'b1, 1'(j == 3), 9'h055});
                if (plan[a-1] >= bufsz) begin e_late = 1; break; end
                if (a == 16) begin e_exc = 1; break; end
                e_rep++;
            end
        end

        idx = 0; att = 0; jam = 0; t_j = 0; cyc = 0; rst_left = 0;
        n_rep = 0; n_ok = 0; n_late = 0; n_exc = 0; n_done = 0;
        armed = 1; active = 1; finished = 0;
        while (!finished && cyc < 40000) begin
            @(negedge clk);
            rst          = (rst_left > 0);
            m_axis_ready = full_ready ? 1'b1 : 1'($urandom_range(0, 1));
            s_axis_valid = active && !rst;
            s_axis_data  = fdata[idx];
            s_axis_last  = (idx == L-1);
            replayable   = (idx < bufsz);
            colnow       = !rst && active && armed && (att < ncol) && m_axis_ready && (idx == plan[att]);
            col          = colnow;
            #1;
            if (rst) begin
                check_eq({name, "_rst_outs"}, 32'(outs), 32'd0);
                rst_left--;
                if (rst_left == 0) finished = 1;
            end else begin
                if (m_axis_valid && m_axis_ready) begin
                    got_q.push_back({m_axis_err, m_axis_last, m_axis_data});
                    if (m_axis_err) begin
                        jam++;
                        if (jam == 4) begin
                            jam = 0; t_j = cyc;
                            if (rst_test) rst_left = 3;
                        end
                    end
                end
                if (replay) begin
                    n_rep++;
                    check_eq({name, "_replay_replayable"}, 32'(replayable), 32'd1);
                    k = (att < BLIM) ? att : BLIM;
                    d = cyc - t_j;
                    gap_ok = (d == 1) || ((d % SLOT == 0) && (d / SLOT < (1 << k)));
                    check_eq({name, "_backoff_gap_ok"}, 32'(gap_ok), 32'd1);
                    idx = 0; armed = 1; active = 1;
                end
                if (done) n_done++;
                n_ok   += int'(tx_ok);
                n_late += int'(late_col);
                n_exc  += int'(excessive);
                if (s_axis_valid && s_axis_ready) begin
                    if (colnow) begin armed = 0; att++; end
                    if (s_axis_last) active = 0;
                    else idx++;
                end
                if (n_done > 0 && !active) finished = 1;
            end
            cyc++;
        end

        check_eq({name, "_finished"}, 32'(finished), 32'd1);
        check_eq({name, "_beats"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got_q.size()) ? got_q[i] : 11'bx;
            check_eq({name, "_beat"}, 32'(g), 32'(exp_q[i]));
        end
        check_eq({name, "_done"},      32'(n_done), rst_test ? 32'd0 : 32'd1);
        check_eq({name, "_replays"},   32'(n_rep),  32'(e_rep));
        check_eq({name, "_tx_ok"},     32'(n_ok),   32'(e_ok));
        check_eq({name, "_late_col"},  32'(n_late), 32'(e_late));
        check_eq({name, "_excessive"}, 32'(n_exc),  32'(e_exc));
    endtask

    initial begin
        int L, n;
        rst = 1'b1; s_axis_valid = 1'b1; s_axis_data = 9'h1AB; s_axis_last = 1'b1;
        replayable = 1'b1; col = 1'b1; m_axis_ready = 1'b1;
        repeat (3) begin
            @(negedge clk); #1;
            check_eq("reset_outs", 32'(outs), 32'd0);
        end
        idle(2);

        run_frame("clean60", 60, BUF, 0, 1, 0);
        idle(3);
        plan[0] = 10;
        run_frame("col_beat10", 60, BUF, 1, 1, 0);
        idle(3);
        for (int a = 0; a < 16; a++) plan[a] = $urandom_range(0, 20);
        run_frame("excessive", 60, BUF, 16, 0, 0);
        idle(5);
        plan[0] = 70;
        run_frame("late_col", 80, BUF, 1, 0, 0);
        idle(5);
        run_frame("after_late", 30, BUF, 0, 0, 0);
        idle(3);
        plan[0] = 19;
        run_frame("col_last_retry", 20, BUF, 1, 0, 0);
        idle(3);
        plan[0] = 59;
        run_frame("col_last_late", 60, BUF, 1, 0, 0);
        idle(3);
        plan[0] = 5;
        run_frame("rst_backoff", 40, BUF, 1, 0, 1);
        idle(3);
        plan[0] = 8;
        run_frame("post_rst", 40, BUF, 1, 0, 0);
        idle(3);
        for (int r = 0; r < 6; r++) begin
            L = $urandom_range(8, 60);
            n = $urandom_range(0, 3);
            for (int i = 0; i < n; i++) plan[i] = $urandom_range(0, (L - 1 < 40) ? L - 1 : 40);
            run_frame("random", L, BUF, n, 0, 0);
            idle(2);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
